// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX/MEM and MEM/WB operand forwarding, load-use stall FSM and saturating event counters
module fwd_hazard_unit #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_ex_rs1,
    input  logic [REG_AW-1:0] id_ex_rs2,
    input  logic [REG_AW-1:0] id_ex_rd,
    input  logic              id_ex_regwrite,
    input  logic              id_ex_memread,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic              ex_mem_regwrite,
    input  logic              ex_mem_memread,
    input  logic [REG_AW-1:0] mem_wb_rd,
    input  logic              mem_wb_regwrite,
    input  logic              mem_wb_memread,
    input  logic              flush,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  fwd_count
);
    typedef enum logic {IDLE, HOLD} stateType;
    stateType state;
    logic [3:0] cnt;
    logic hz;
    // A load still in EX/MEM has no data yet, so it is never a forwarding source
    function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] rs);
        return (ex_mem_regwrite && !ex_mem_memread && ex_mem_rd != '0 && ex_mem_rd == rs) ? 2'b11 :
               (mem_wb_regwrite && mem_wb_rd != '0 && mem_wb_rd == rs) ? (mem_wb_memread ? 2'b01 : 2'b10) :
               2'b00;
    endfunction
    always_comb begin
        hz = id_ex_memread && id_ex_regwrite && id_ex_rd != '0 && (id_ex_rd == id_rs1 || id_ex_rd == id_rs2);
        forward_a = rst ? 2'b00 : fwdSel(id_ex_rs1);
        forward_b = rst ? 2'b00 : fwdSel(id_ex_rs2);
        stall = !rst && !flush && (state == HOLD || hz);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            stall_count <= '0;
            fwd_count   <= '0;
        end else begin
            if (state == IDLE) begin
                if (hz && !flush && LOAD_LAT > 1) begin
                    state <= HOLD;
                    cnt   <= 4'(LOAD_LAT - 1);
                end
            end else if (flush || cnt == 4'd1) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt - 4'd1;
            end
            if (stall && stall_count != '1)
                stall_count <= stall_count + CNT_W'(1);
            if ((forward_a != 2'b00 || forward_b != 2'b00) && fwd_count != '1)
                fwd_count <= fwd_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: two configurations (LOAD_LAT=1/CNT_W=16, LOAD_LAT=3/CNT_W=4) against a bubble-count model
module tb_fwd_hazard_unit;
    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs1, id_rs2, id_ex_rs1, id_ex_rs2, id_ex_rd, ex_mem_rd, mem_wb_rd;
    logic id_ex_regwrite, id_ex_memread, ex_mem_regwrite, ex_mem_memread;
    logic mem_wb_regwrite, mem_wb_memread, flush;
    logic [1:0] fa1, fb1, fa3, fb3;
    logic st1, st3;
    logic [15:0] sc1o, fc1o;
    logic [3:0] sc3o, fc3o;
    int checks = 0, errors = 0;
    int rem1, rem3, msc1, msc3, mfc1, mfc3;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) d1 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
        .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread),
        .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_memread(ex_mem_memread),
        .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_memread(mem_wb_memread),
        .flush(flush), .forward_a(fa1), .forward_b(fb1), .stall(st1),
        .stall_count(sc1o), .fwd_count(fc1o));

    fwd_hazard_unit #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(4)) d3 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
        .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread),
        .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_memread(ex_mem_memread),
        .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_memread(mem_wb_memread),
        .flush(flush), .forward_a(fa3), .forward_b(fb3), .stall(st3),
        .stall_count(sc3o), .fwd_count(fc3o));

    // Reference model: forwarding from the priority rules, stalls as a count of bubbles still owed
    function automatic logic [1:0] expFwd(input logic [4:0] rs);
        if (rst || rs == 5'd0) return 2'b00;
        if (ex_mem_regwrite && !ex_mem_memread && ex_mem_rd == rs) return 2'b11;
        if (mem_wb_regwrite && mem_wb_rd == rs) return mem_wb_memread ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    function automatic logic expHz();
        return id_ex_memread && id_ex_regwrite && id_ex_rd != 5'd0 &&
               (id_ex_rd == id_rs1 || id_ex_rd == id_rs2);
    endfunction

    function automatic logic expStall(input int rem);
        if (rst || flush) return 1'b0;
        return rem > 0 ? 1'b1 : expHz();
    endfunction

    function automatic int nextRem(input int rem, input int lat);
        if (rem > 0) return flush ? 0 : rem - 1;
        return (expHz() && !flush) ? lat - 1 : 0;
    endfunction

    task automatic tick();
        logic s1, s3, f;
        s1 = expStall(rem1);
        s3 = expStall(rem3);
        f = expFwd(id_ex_rs1) != 2'b00 || expFwd(id_ex_rs2) != 2'b00;
        @(posedge clk);
        if (rst) begin
            rem1 = 0; rem3 = 0; msc1 = 0; msc3 = 0; mfc1 = 0; mfc3 = 0;
        end else begin
            if (s1 && msc1 < 65535) msc1++;
            if (s3 && msc3 < 15) msc3++;
            if (f && mfc1 < 65535) mfc1++;
            if (f && mfc3 < 15) mfc3++;
            rem1 = nextRem(rem1, 1);
            rem3 = nextRem(rem3, 3);
        end
        @(negedge clk);
    endtask

    task automatic clearIn();
        {id_rs1, id_rs2, id_ex_rs1, id_ex_rs2, id_ex_rd, ex_mem_rd, mem_wb_rd} = '0;
        {id_ex_regwrite, id_ex_memread, ex_mem_regwrite, ex_mem_memread} = '0;
        {mem_wb_regwrite, mem_wb_memread, flush} = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        id_ex_rd = 5'd9; id_ex_memread = 1'b1; id_ex_regwrite = 1'b1; id_rs1 = 5'd9;
        ex_mem_rd = 5'd5; ex_mem_regwrite = 1'b1; id_ex_rs1 = 5'd5;
        #1;
        checks++; if (st1 !== 1'b0 || st3 !== 1'b0) begin errors++; $display("FAIL reset_stall got %b/%b want 0/0", st1, st3); end
        checks++; if (fa1 !== 2'b00 || fa3 !== 2'b00) begin errors++; $display("FAIL reset_fwd got %b/%b want 00/00", fa1, fa3); end
        tick();
        checks++; if (sc1o !== 16'd0 || fc1o !== 16'd0) begin errors++; $display("FAIL reset_cnt1 got %0d/%0d want 0/0", sc1o, fc1o); end
        checks++; if (sc3o !== 4'd0 || fc3o !== 4'd0) begin errors++; $display("FAIL reset_cnt3 got %0d/%0d want 0/0", sc3o, fc3o); end
        rst = 1'b0;
        clearIn();
        #1;
        checks++; if (st1 !== 1'b0 || fa1 !== 2'b00) begin errors++; $display("FAIL reset_idle got %b/%b want 0/00", st1, fa1); end
        tick();
    endtask

    task automatic test_forwarding();
        ex_mem_rd = 5'd5; ex_mem_regwrite = 1'b1; ex_mem_memread = 1'b0;
        mem_wb_rd = 5'd5; mem_wb_regwrite = 1'b1; mem_wb_memread = 1'b1;
        id_ex_rs1 = 5'd5; id_ex_rs2 = 5'd5;
        #1;
        checks++; if (fa1 !== 2'b11 || fb1 !== 2'b11) begin errors++; $display("FAIL fwd_exmem got %b/%b want 11/11", fa1, fb1); end
        tick();
        checks++; if (fc1o !== 16'(mfc1) || fc1o !== 16'd1) begin errors++; $display("FAIL fwd_count got %0d want %0d", fc1o, mfc1); end
        ex_mem_rd = 5'd3; mem_wb_rd = 5'd7; id_ex_rs1 = 5'd7; id_ex_rs2 = 5'd0;
        #1;
        checks++; if (fa1 !== 2'b01 || fb1 !== 2'b00) begin errors++; $display("FAIL fwd_memwb_load got %b/%b want 01/00", fa1, fb1); end
        tick();
        mem_wb_rd = 5'd0;
        #1;
        checks++; if (fa1 !== 2'b00 || fb1 !== 2'b00) begin errors++; $display("FAIL fwd_rd0 got %b/%b want 00/00", fa1, fb1); end
        tick();
        for (int i = 0; i < 60; i++) begin
            ex_mem_rd = 5'($urandom_range(0, 3)); mem_wb_rd = 5'($urandom_range(0, 3));
            id_ex_rs1 = 5'($urandom_range(0, 3)); id_ex_rs2 = 5'($urandom_range(0, 3));
            {ex_mem_regwrite, ex_mem_memread, mem_wb_regwrite, mem_wb_memread} = 4'($urandom);
            #1;
            checks++; if (fa1 !== expFwd(id_ex_rs1) || fa3 !== expFwd(id_ex_rs1)) begin errors++; $display("FAIL fwd_a_rand got %b/%b want %b", fa1, fa3, expFwd(id_ex_rs1)); end
            checks++; if (fb1 !== expFwd(id_ex_rs2) || fb3 !== expFwd(id_ex_rs2)) begin errors++; $display("FAIL fwd_b_rand got %b/%b want %b", fb1, fb3, expFwd(id_ex_rs2)); end
            tick();
            checks++; if (fc1o !== 16'(mfc1) || fc3o !== 4'(mfc3)) begin errors++; $display("FAIL fwd_count_rand got %0d/%0d want %0d/%0d", fc1o, fc3o, mfc1, mfc3); end
        end
        clearIn();
    endtask

    task automatic test_load_use();
        logic [1:0] seq [8] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00};
        logic exp1 [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic exp3 [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        id_ex_rd = 5'd9; id_rs2 = 5'd9;
        for (int i = 0; i < 8; i++) begin
            {id_ex_memread, flush} = seq[i];
            id_ex_regwrite = id_ex_memread;
            #1;
            checks++; if (st1 !== exp1[i] || st1 !== expStall(rem1)) begin errors++; $display("FAIL lu_stall1[%0d] got %b want %b", i, st1, exp1[i]); end
            checks++; if (st3 !== exp3[i] || st3 !== expStall(rem3)) begin errors++; $display("FAIL lu_stall3[%0d] got %b want %b", i, st3, exp3[i]); end
            tick();
            checks++; if (sc1o !== 16'(msc1) || sc3o !== 4'(msc3)) begin errors++; $display("FAIL lu_count[%0d] got %0d/%0d want %0d/%0d", i, sc1o, sc3o, msc1, msc3); end
        end
        clearIn();
    endtask

    task automatic test_zero_and_reset_hold();
        id_ex_rd = 5'd0; id_rs1 = 5'd0; id_ex_memread = 1'b1; id_ex_regwrite = 1'b1;
        #1;
        checks++; if (st1 !== 1'b0 || st3 !== 1'b0 || fa1 !== 2'b00) begin errors++; $display("FAIL rd0_load got %b/%b/%b want 0/0/00", st1, st3, fa1); end
        tick();
        id_ex_rd = 5'd9; id_rs1 = 5'd9;
        #1;
        checks++; if (st3 !== 1'b1) begin errors++; $display("FAIL hold_entry got %b want 1", st3); end
        tick();
        id_ex_memread = 1'b0; id_ex_regwrite = 1'b0; rst = 1'b1;
        #1;
        checks++; if (st3 !== 1'b0) begin errors++; $display("FAIL rst_in_hold got %b want 0", st3); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (sc3o !== 4'd0 || fc3o !== 4'd0 || sc1o !== 16'd0 || fc1o !== 16'd0) begin errors++; $display("FAIL rst_counts got %0d/%0d/%0d/%0d want 0", sc3o, fc3o, sc1o, fc1o); end
        checks++; if (st3 !== 1'b0 || st3 !== expStall(rem3)) begin errors++; $display("FAIL after_rst_stall got %b want 0", st3); end
        tick();
        clearIn();
    endtask

    task automatic test_saturation();
        id_ex_rd = 5'd9; id_rs1 = 5'd9; id_ex_memread = 1'b1; id_ex_regwrite = 1'b1;
        ex_mem_rd = 5'd5; ex_mem_regwrite = 1'b1; id_ex_rs1 = 5'd5;
        for (int i = 0; i < 20; i++) begin
            #1;
            checks++; if (st3 !== expStall(rem3) || st1 !== expStall(rem1)) begin errors++; $display("FAIL sat_stall[%0d] got %b/%b want %b/%b", i, st1, st3, expStall(rem1), expStall(rem3)); end
            tick();
        end
        checks++; if (sc3o !== 4'd15 || fc3o !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d/%0d want 15/15", sc3o, fc3o); end
        checks++; if (sc1o !== 16'(msc1) || fc1o !== 16'(mfc1)) begin errors++; $display("FAIL sat_wide got %0d/%0d want %0d/%0d", sc1o, fc1o, msc1, mfc1); end
        clearIn();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 7) == 0);
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            id_ex_rs1 = 5'($urandom_range(0, 3)); id_ex_rs2 = 5'($urandom_range(0, 3));
            id_ex_rd = 5'($urandom_range(0, 3)); ex_mem_rd = 5'($urandom_range(0, 3)); mem_wb_rd = 5'($urandom_range(0, 3));
            {id_ex_regwrite, id_ex_memread, ex_mem_regwrite, ex_mem_memread, mem_wb_regwrite, mem_wb_memread} = 6'($urandom);
            #1;
            checks++; if (fa1 !== expFwd(id_ex_rs1) || fb1 !== expFwd(id_ex_rs2)) begin errors++; $display("FAIL rand_fwd[%0d] got %b/%b want %b/%b", i, fa1, fb1, expFwd(id_ex_rs1), expFwd(id_ex_rs2)); end
            checks++; if (st1 !== expStall(rem1) || st3 !== expStall(rem3)) begin errors++; $display("FAIL rand_stall[%0d] got %b/%b want %b/%b", i, st1, st3, expStall(rem1), expStall(rem3)); end
            tick();
            checks++; if (sc1o !== 16'(msc1) || sc3o !== 4'(msc3)) begin errors++; $display("FAIL rand_scnt[%0d] got %0d/%0d want %0d/%0d", i, sc1o, sc3o, msc1, msc3); end
            checks++; if (fc1o !== 16'(mfc1) || fc3o !== 4'(mfc3)) begin errors++; $display("FAIL rand_fcnt[%0d] got %0d/%0d want %0d/%0d", i, fc1o, fc3o, mfc1, mfc3); end
        end
        rst = 1'b0;
        clearIn();
    endtask

    initial begin
        rst = 1'b1;
        clearIn();
        {rem1, rem3, msc1, msc3, mfc1, mfc3} = '0;
        @(negedge clk);
        test_reset();
        test_forwarding();
        test_load_use();
        test_zero_and_reset_hold();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
